// File: rtl/rv32_pkg.sv
// Shared RV32 constants: arbiter FSM state codes and memory access width codes.
package rv32_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and the
// data stage, with a starvation guard that bounds how long fetch can be held off.
module mem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_width,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_width,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;
  logic          drop;
  logic          grant_d;
  logic          grant_i;
  logic          ack_i;
  logic          ack_d;

  // Data wins a tie unless fetch has already lost STARVE times in a row.
  always_comb begin
    grant_d = (state == IDLE) && d_req && (!if_req || (starve_cnt != STARVE_MAX));
    grant_i = (state == IDLE) && if_req && !grant_d;
    ack_i   = (state == BUSY_I) && mem_ack;
    ack_d   = (state == BUSY_D) && mem_ack;
  end

  assign if_valid  = ack_i && !drop;
  assign d_valid   = ack_d;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign stall_if  = if_req && !if_valid;
  assign stall_mem = d_req && !d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_width  <= 3'b000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      drop       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_width <= d_width;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_width <= WORD;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
          end

          if (!if_req || grant_i) begin
            starve_cnt <= '0;
          end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
          end

          // A redirect arriving with the fetch grant still discards that fetch.
          if (grant_i && if_kill) begin
            drop <= 1'b1;
          end
        end

        BUSY_I, BUSY_D: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            drop    <= 1'b0;
          end else if ((state == BUSY_I) && if_kill) begin
            drop <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          drop    <= 1'b0;
        end
      endcase
    end
  end

endmodule
